// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch port and a data port.
// Data accesses have priority. A saturating starvation counter hands a contested grant to fetch.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
    localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state, next_state;
    logic       owner_d;      // 1: data port owns the current access
    logic       lat_we;
    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       grant;
    logic       grant_d;
    logic       capture;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_d    = 1'b0;
        capture    = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        if_ack     = 1'b0;
        d_ack      = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant      = 1'b1;
                    // fetch takes a contested grant only once data has starved it
                    grant_d    = d_req && !(if_req && (starve_cnt == STARVE_C));
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                mem_we     = lat_we;
                mem_re     = !lat_we;
                next_state = lat_we ? DONE : WAIT;
            end
            WAIT: begin
                if (lat_cnt == RD_LAT_C) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if_ack     = !owner_d;
                d_ack      = owner_d;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d    <= 1'b0;
            lat_we     <= 1'b0;
            lat_cnt    <= 4'd0;
            starve_cnt <= 4'd0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if (grant) begin
                owner_d  <= grant_d;
                lat_we   <= grant_d & d_we;
                mem_addr <= grant_d ? d_addr : if_addr;
                if (grant_d) begin
                    mem_wdata <= d_wdata;
                    if (!if_req)                     starve_cnt <= 4'd0;
                    else if (starve_cnt != STARVE_C) starve_cnt <= starve_cnt + 4'd1;
                end else begin
                    starve_cnt <= 4'd0;
                end
            end
            if (state == ISSUE)
                lat_cnt <= 4'd1;
            else if (state == WAIT && !capture)
                lat_cnt <= lat_cnt + 4'd1;
            if (capture) begin
                if (owner_d) d_rdata  <= mem_rdata;
                else         if_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at RD_LAT=2 and one at RD_LAT=1,
// each backed by a memory model returning addr ^ 16'hA5A5 exactly RD_LAT cycles after mem_re.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // RD_LAT = 2 instance
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, d_ack, mem_re, mem_we, busy;

    // RD_LAT = 1 instance
    logic        if_req1 = 1'b0;
    logic [15:0] if_addr1 = '0;
    logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_ack1, d_ack1, mem_re1, mem_we1, busy1;

    mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_rdata(d_rdata1), .d_ack(d_ack1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_re(mem_re1), .mem_we(mem_we1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    // memory models: read data is only valid in the exact capture cycle
    logic [15:0] pd0, pd1, qd0;
    logic        pv0 = 1'b0, pv1 = 1'b0, qv0 = 1'b0;
    always @(posedge clk) begin
        pv0 <= mem_re;  pd0 <= mem_addr ^ 16'hA5A5;
        pv1 <= pv0;     pd1 <= pd0;
        qv0 <= mem_re1; qd0 <= mem_addr1 ^ 16'hA5A5;
    end
    assign mem_rdata  = pv1 ? pd1 : 16'hDEAD;
    assign mem_rdata1 = qv0 ? qd0 : 16'hDEAD;

    // event monitors sampled mid-cycle
    int if_ack_cnt = 0, d_ack_cnt = 0, re_cnt = 0, we_cnt = 0, collide_cnt = 0;
    always @(negedge clk) begin
        if (if_ack === 1'b1) if_ack_cnt <= if_ack_cnt + 1;
        if (d_ack === 1'b1)  d_ack_cnt  <= d_ack_cnt + 1;
        if (mem_re === 1'b1) re_cnt     <= re_cnt + 1;
        if (mem_we === 1'b1) we_cnt     <= we_cnt + 1;
        if (mem_re === 1'b1 && mem_we === 1'b1) collide_cnt <= collide_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int ia, da, ra, wa, cyc;

    initial begin
        // reset
        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {mem_re, mem_we, if_ack, d_ack}, 4'b0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        chk("rst_rdata", {if_rdata, d_rdata}, 32'h0);
        rst = 1'b0;
        tick();

        // single fetch
        ia = if_ack_cnt; da = d_ack_cnt;
        if_req = 1'b1; if_addr = 16'h0010;
        tick();
        chk("f1_re", {mem_re, mem_we}, 2'b10);
        chk("f1_addr", mem_addr, 16'h0010);
        chk("f1_busy", busy, 1'b1);
        tick();
        chk("f1_re_once", mem_re, 1'b0);
        tick();
        chk("f1_no_early_ack", if_ack, 1'b0);
        tick();
        chk("f1_ack", if_ack, 1'b1);
        chk("f1_rdata", if_rdata, 16'hA5B5);
        chk("f1_d_ack", d_ack, 1'b0);
        if_req = 1'b0;
        tick();
        chk("f1_idle", {busy, if_ack}, 2'b00);
        chk("f1_ack_counts", {16'(if_ack_cnt - ia), 16'(d_ack_cnt - da)}, {16'd1, 16'd0});

        // data write
        ra = re_cnt; da = d_ack_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
        tick();
        chk("w_strobes", {mem_re, mem_we}, 2'b01);
        chk("w_addr", mem_addr, 16'h0200);
        chk("w_wdata", mem_wdata, 16'h1234);
        tick();
        chk("w_ack", {d_ack, if_ack, mem_we}, 3'b100);
        chk("w_mem_addr_hold", mem_addr, 16'h0200);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("w_idle", {busy, d_ack}, 2'b00);
        chk("w_no_read", re_cnt - ra, 0);
        chk("w_one_ack", d_ack_cnt - da, 1);

        // simultaneous requests: data first, then fetch
        d_req = 1'b1; d_addr = 16'h0300; if_req = 1'b1; if_addr = 16'h0004;
        tick();
        chk("s_data_first", mem_addr, 16'h0300);
        chk("s_re", mem_re, 1'b1);
        tick(); tick(); tick();
        chk("s_d_ack", {d_ack, if_ack}, 2'b10);
        chk("s_d_rdata", d_rdata, 16'hA6A5);
        chk("s_if_rdata_untouched", if_rdata, 16'hA5B5);
        d_req = 1'b0;
        tick();
        chk("s_idle_gap", busy, 1'b0);
        tick();
        chk("s_fetch_addr", mem_addr, 16'h0004);
        chk("s_fetch_re", mem_re, 1'b1);
        tick(); tick();
        chk("s_fetch_wait", if_ack, 1'b0);
        tick();
        chk("s_if_ack", {if_ack, d_ack}, 2'b10);
        chk("s_if_rdata", if_rdata, 16'hA5A1);
        chk("s_d_rdata_untouched", d_rdata, 16'hA6A5);
        if_req = 1'b0;
        tick();

        // starvation: four contested data grants, then fetch, then data again
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400; if_req = 1'b1; if_addr = 16'h0020;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("starve_grant_%0d", k), mem_addr, (k == 5) ? 16'h0020 : 16'h0400);
            tick(); tick(); tick();
            chk($sformatf("starve_ack_%0d", k), {if_ack, d_ack}, (k == 5) ? 2'b10 : 2'b01);
            tick();
        end
        d_req = 1'b0; if_req = 1'b0;
        tick();

        // reset while waiting for read data
        if_req = 1'b1; if_addr = 16'h0030;
        tick();
        chk("r_re", mem_re, 1'b1);
        tick();
        rst = 1'b1;
        ia = if_ack_cnt; da = d_ack_cnt;
        tick();
        chk("r_busy", busy, 1'b0);
        chk("r_outputs", {mem_re, mem_we, if_ack, d_ack}, 4'b0000);
        chk("r_regs", {mem_addr, if_rdata}, 32'h0);
        chk("r_regs2", {mem_wdata, d_rdata}, 32'h0);
        rst = 1'b0; if_req = 1'b0;
        ra = re_cnt; wa = we_cnt;
        tick(); tick(); tick();
        chk("r_no_ack", {16'(if_ack_cnt - ia), 16'(d_ack_cnt - da)}, 32'h0);
        chk("r_no_strobe", {16'(re_cnt - ra), 16'(we_cnt - wa)}, 32'h0);
        if_req = 1'b1; if_addr = 16'h0010;
        tick();
        chk("r_after_re", mem_re, 1'b1);
        tick(); tick(); tick();
        chk("r_after_ack", if_ack, 1'b1);
        chk("r_after_rdata", if_rdata, 16'hA5B5);
        if_req = 1'b0;
        tick();

        // back-to-back fetch, RD_LAT = 2
        if_req = 1'b1; if_addr = 16'h0100;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin tick(); cyc++; end while (if_ack !== 1'b1 && cyc < 20);
            chk($sformatf("b2b2_period_%0d", k), cyc, (k == 0) ? 4 : 5);
            chk($sformatf("b2b2_rdata_%0d", k), if_rdata, (16'h0100 + 16'(k)) ^ 16'hA5A5);
            if (k < 2) if_addr = 16'h0100 + 16'(k + 1);
            else       if_req = 1'b0;
        end
        tick();

        // back-to-back fetch, RD_LAT = 1
        if_req1 = 1'b1; if_addr1 = 16'h0200;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin tick(); cyc++; end while (if_ack1 !== 1'b1 && cyc < 20);
            chk($sformatf("b2b1_period_%0d", k), cyc, (k == 0) ? 3 : 4);
            chk($sformatf("b2b1_rdata_%0d", k), if_rdata1, (16'h0200 + 16'(k)) ^ 16'hA5A5);
            if (k < 2) if_addr1 = 16'h0200 + 16'(k + 1);
            else       if_req1 = 1'b0;
        end
        tick();
        chk("b2b1_idle", {busy1, d_ack1, mem_we1}, 3'b000);

        chk("strobe_exclusive", collide_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port 16-bit memory between the CPU core's instruction-fetch port and its data port.
- Accepts level-held requests from both ports and grants one at a time.
- Issues a single-cycle memory strobe, waits a fixed read latency, then returns data with a one-cycle acknowledge.
- Data accesses have priority; a starvation counter guarantees instruction-fetch progress.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- RD_LAT, 2, memory read latency in cycles from strobe to valid mem_rdata (legal range 1..15).
- STARVE_MAX, 4, consecutive contested data grants after which instruction fetch wins the next contested grant (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  instruction-fetch read request, level, held until if_ack.
- if_addr  in  AW  fetch address, stable while if_req high.
- if_rdata  out  DW  fetched word; valid with if_ack, then held.
- if_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request, level, held until d_ack.
- d_we  in  1  1=write, 0=read; stable while d_req high.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  read data; valid with d_ack, then held.
- d_ack  out  1  one-cycle completion pulse for data.
- mem_addr  out  AW  memory address (registered).
- mem_wdata  out  DW  memory write data (registered).
- mem_re  out  1  read strobe, exactly one cycle per read.
- mem_we  out  1  write strobe, exactly one cycle per write.
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after the mem_re cycle.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: state IDLE; all outputs 0 (if_rdata, d_rdata, mem_addr, mem_wdata, strobes, acks, busy); starvation counter 0.
- FSM states and transitions:
  - IDLE: if any request is high, pick the winner and latch owner, addr, we and wdata, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): mem_addr/mem_wdata equal the latched values. mem_re=1 for a read, mem_we=1 for a write. Write goes to DONE; read goes to WAIT with the latency counter set to 1.
  - WAIT: when counter==RD_LAT, capture mem_rdata into the owner's rdata register and go to DONE. Otherwise increment the counter.
  - DONE (1 cycle): the owner's ack=1, then go to IDLE.
- Timing from grant cycle G:
  - Read: mem_re at G+1, capture at G+1+RD_LAT, ack at G+2+RD_LAT.
  - Write: mem_we at G+1, ack at G+2.
  - Back-to-back read period is RD_LAT+3.
- Handshake: a requester drops or changes req/addr at the clock edge ending its ack cycle. IDLE samples the new request on the following cycle.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each data grant made while if_req is high.
  - Clears on any fetch grant, and on a data grant while if_req is low.
- Strobe rules:
  - mem_re and mem_we are never high together.
  - Strobes are high only in ISSUE.
  - mem_addr/mem_wdata hold their last values outside ISSUE.
- rdata registers update only in the capture cycle of their own port; the other port's rdata is untouched.
- Requests arriving while busy are ignored until IDLE; no queueing.
- Reset mid-operation (any state): next cycle is IDLE with all outputs 0. No ack is issued for the aborted access, and no strobe is issued afterward.
- Ack is never asserted for a port that was not the latched owner.

Test Plan:
- Single fetch (RD_LAT=2; memory model returns addr^16'hA5A5): if_req with if_addr=16'h0010 at G → mem_re=1 and mem_addr=16'h0010 at G+1 only; if_ack at G+4 with if_rdata=16'hA5B5; d_ack stays 0.
- Data write: d_req, d_we=1, d_addr=16'h0200, d_wdata=16'h1234 at G → mem_we=1 with addr 16'h0200 and wdata 16'h1234 at G+1; d_ack at G+2; mem_re never high.
- Simultaneous requests from IDLE: data read at 16'h0300 plus fetch at 16'h0004 → data served first (d_ack at G+4, d_rdata=16'hA6A5), then fetch granted at G+5 with if_ack at G+9 and if_rdata=16'hA5A1.
- Starvation: d_req held continuously with reads and if_req held → data grants 1–4, then the 5th grant goes to fetch; counter returns to 0, and the next contested grant goes to data.
- Reset in WAIT: rst high one cycle after mem_re → no ack on either port, busy=0, outputs 0; a following fetch to 16'h0010 completes normally with if_ack after 4 cycles.
- Back-to-back fetch: a new if_addr is presented on the edge ending the ack → acks repeat every 5 cycles (RD_LAT=2); rerun with RD_LAT=1 to confirm every 4 cycles.
